// File: rtl/mult_rr_arbiter_if.sv
// Bundles the requester bus for mult_rr_arbiter.
// MULT_ARB_STALL_EN adds the P_rdy_i result back-pressure signal.
interface mult_rr_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_i;
    logic [NREQ*8-1:0] C_i;
    logic [NREQ*8-1:0] SP_i;
    logic [NREQ-1:0]   C0_i;
    logic [NREQ-1:0]   gnt_o;
    logic [8:0]        P_o;
    logic              P_vld_o;
    logic [IDW-1:0]    P_id_o;

`ifdef MULT_ARB_STALL_EN
    logic              P_rdy_i;

    modport master (
        output req_i, C_i, SP_i, C0_i, P_rdy_i,
        input  gnt_o, P_o, P_vld_o, P_id_o
    );
    modport slave (
        input  req_i, C_i, SP_i, C0_i, P_rdy_i,
        output gnt_o, P_o, P_vld_o, P_id_o
    );
`else
    modport master (
        output req_i, C_i, SP_i, C0_i,
        input  gnt_o, P_o, P_vld_o, P_id_o
    );
    modport slave (
        input  req_i, C_i, SP_i, C0_i,
        output gnt_o, P_o, P_vld_o, P_id_o
    );
`endif
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one mult_csa between NREQ requesters, 2-stage registered pipe.
// MULT_ARB_STALL_EN enables P_rdy_i back-pressure on the result stage.

// Carry-select adder: low nibble sum selects between precomputed high-nibble sums.
module mult_csa (
    input  logic [7:0] c_i,
    input  logic [7:0] sp_i,
    input  logic       c0_i,
    output logic [8:0] p_o
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    assign lo  = {1'b0, c_i[3:0]} + {1'b0, sp_i[3:0]} + {4'b0, c0_i};
    assign hi0 = {1'b0, c_i[7:4]} + {1'b0, sp_i[7:4]};
    assign hi1 = hi0 + 5'd1;
    assign p_o = {(lo[4] ? hi1 : hi0), lo[3:0]};
endmodule

module mult_rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    mult_rr_arbiter_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0]  last_q;
    logic            s1_vld_q;
    logic [7:0]      s1_c_q;
    logic [7:0]      s1_sp_q;
    logic            s1_c0_q;
    logic [IDW-1:0]  s1_id_q;
    logic [8:0]      p_q;
    logic            p_vld_q;
    logic [IDW-1:0]  p_id_q;

    logic [8:0]      prod;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  win_id;
    logic            xfer;
    logic            out_adv;
    logic            s1_load;
    logic [7:0]      sel_c;
    logic [7:0]      sel_sp;
    logic            sel_c0;

`ifdef MULT_ARB_STALL_EN
    assign out_adv = !(p_vld_q && !bus.P_rdy_i);
`else
    assign out_adv = 1'b1;
`endif
    // Stage 1 can take a new item unless it is full and the output is stalled.
    assign s1_load = out_adv || !s1_vld_q;

    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        logic           found;
        gnt    = '0;
        win_id = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            sum = {1'b0, last_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (!found && bus.req_i[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win_id   = idx;
            end
        end
        if (rst_i || !s1_load) begin
            gnt = '0;
        end
    end

    assign xfer = |gnt;

    always_comb begin
        sel_c  = '0;
        sel_sp = '0;
        sel_c0 = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (gnt[k]) begin
                sel_c  = bus.C_i[8*k +: 8];
                sel_sp = bus.SP_i[8*k +: 8];
                sel_c0 = bus.C0_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q   <= IDW'(NREQ - 1);
            s1_vld_q <= 1'b0;
            s1_c_q   <= '0;
            s1_sp_q  <= '0;
            s1_c0_q  <= 1'b0;
            s1_id_q  <= '0;
        end else if (s1_load) begin
            s1_vld_q <= xfer;
            if (xfer) begin
                last_q  <= win_id;
                s1_c_q  <= sel_c;
                s1_sp_q <= sel_sp;
                s1_c0_q <= sel_c0;
                s1_id_q <= win_id;
            end
        end
    end

    mult_csa u_mult_csa (
        .c_i  (s1_c_q),
        .sp_i (s1_sp_q),
        .c0_i (s1_c0_q),
        .p_o  (prod)
    );

    // P_o/P_id_o keep their last value across idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
            p_id_q  <= '0;
        end else if (out_adv) begin
            p_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                p_q    <= prod;
                p_id_q <= s1_id_q;
            end
        end
    end

    assign bus.gnt_o   = gnt;
    assign bus.P_o     = p_q;
    assign bus.P_vld_o = p_vld_q;
    assign bus.P_id_o  = p_id_q;
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Self-checking bench for mult_rr_arbiter: directed vector table, reset/stall sequences,
// and randomized traffic against a queue-based reference model.
module tb_mult_rr_arbiter;
    localparam logic [31:0] CA = 32'h04030201;
    localparam logic [31:0] SA = 32'h40302010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mult_rr_arbiter_if #(.NREQ(4)) bus ();

    mult_rr_arbiter #(.NREQ(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [8:0] p;
        int         id;
        int         edge_n;
    } item_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] c;
        logic [31:0] sp;
        logic [3:0]  c0;
        logic [3:0]  gnt;
        logic        vld;
        logic [1:0]  id;
        logic [8:0]  p;
    } vec_t;

    item_t      q[$];
    int         m_last;
    logic [8:0] m_p;
    int         m_id;
    int         ecount = 0;

    function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin);
        return 9'(a) + 9'(b) + 9'(cin);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 3;
        m_p    = '0;
        m_id   = 0;
    endtask

    // Drive one cycle of inputs, check the grant, clock once, then check the result stage.
    task automatic step(input logic [3:0] req, input logic [31:0] c, input logic [31:0] sp,
                        input logic [3:0] c0, input logic rdy, output logic [3:0] g);
        int         w;
        logic [3:0] eg;
        logic       blocked;
        logic       disp;
        logic       exp_vld;
        item_t      it;
        bus.req_i = req;
        bus.C_i   = c;
        bus.SP_i  = sp;
        bus.C0_i  = c0;
`ifdef MULT_ARB_STALL_EN
        bus.P_rdy_i = rdy;
`endif
        #1;
        w = -1;
        for (int i = 1; i <= 4; i++) begin
            if (w < 0 && req[(m_last + i) % 4]) w = (m_last + i) % 4;
        end
        disp    = q.size() > 0 && q[0].edge_n < ecount;
        blocked = q.size() == 2 && !rdy;
        eg      = (w >= 0 && !blocked) ? 4'(1 << w) : 4'b0;
        g       = bus.gnt_o;
        chk("gnt", 32'(g), 32'(eg));
        @(posedge clk);
        ecount++;
        if (disp && rdy) void'(q.pop_front());
        if (eg != 4'b0) begin
            it.p      = golden(c[w*8 +: 8], sp[w*8 +: 8], c0[w]);
            it.id     = w;
            it.edge_n = ecount;
            q.push_back(it);
            m_last = w;
        end
        #1;
        exp_vld = 1'b0;
        if (q.size() > 0 && q[0].edge_n < ecount) begin
            exp_vld = 1'b1;
            m_p     = q[0].p;
            m_id    = q[0].id;
        end
        chk("p_vld", 32'(bus.P_vld_o), 32'(exp_vld));
        chk("p", 32'(bus.P_o), 32'(m_p));
        chk("p_id", 32'(bus.P_id_o), 32'(m_id));
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
    endtask

    vec_t       tbl[19];
    logic [3:0] g;
    logic [7:0] oc[4];
    logic [7:0] os[4];
    logic [3:0] oc0;
    logic [3:0] pend;
    logic [31:0] cv;
    logic [31:0] sv;
    logic        rdy_r;

    initial begin
        // Fairness from reset, single request, then wrap/skip.
        tbl[0]  = '{4'hf, CA, SA, 4'ha, 4'h1, 1'b0, 2'd0, 9'h000};
        tbl[1]  = '{4'hf, CA, SA, 4'ha, 4'h2, 1'b1, 2'd0, 9'h011};
        tbl[2]  = '{4'hf, CA, SA, 4'ha, 4'h4, 1'b1, 2'd1, 9'h023};
        tbl[3]  = '{4'hf, CA, SA, 4'ha, 4'h8, 1'b1, 2'd2, 9'h033};
        tbl[4]  = '{4'hf, CA, SA, 4'ha, 4'h1, 1'b1, 2'd3, 9'h045};
        tbl[5]  = '{4'hf, CA, SA, 4'ha, 4'h2, 1'b1, 2'd0, 9'h011};
        tbl[6]  = '{4'hf, CA, SA, 4'ha, 4'h4, 1'b1, 2'd1, 9'h023};
        tbl[7]  = '{4'hf, CA, SA, 4'ha, 4'h8, 1'b1, 2'd2, 9'h033};
        tbl[8]  = '{4'h0, CA, SA, 4'ha, 4'h0, 1'b1, 2'd3, 9'h045};
        tbl[9]  = '{4'h0, CA, SA, 4'ha, 4'h0, 1'b0, 2'd3, 9'h045};
        tbl[10] = '{4'h4, 32'h00120000, 32'h00340000, 4'h4, 4'h4, 1'b0, 2'd3, 9'h045};
        tbl[11] = '{4'h0, 32'h00120000, 32'h00340000, 4'h4, 4'h0, 1'b1, 2'd2, 9'h047};
        tbl[12] = '{4'h0, 32'h00120000, 32'h00340000, 4'h4, 4'h0, 1'b0, 2'd2, 9'h047};
        tbl[13] = '{4'h3, CA, SA, 4'ha, 4'h1, 1'b0, 2'd2, 9'h047};
        tbl[14] = '{4'h2, CA, SA, 4'ha, 4'h2, 1'b1, 2'd0, 9'h011};
        tbl[15] = '{4'h9, CA, SA, 4'ha, 4'h8, 1'b1, 2'd1, 9'h023};
        tbl[16] = '{4'h1, CA, SA, 4'ha, 4'h1, 1'b1, 2'd3, 9'h045};
        tbl[17] = '{4'h0, CA, SA, 4'ha, 4'h0, 1'b1, 2'd0, 9'h011};
        tbl[18] = '{4'h0, CA, SA, 4'ha, 4'h0, 1'b0, 2'd0, 9'h011};

        bus.req_i = 4'hf;
        bus.C_i   = CA;
        bus.SP_i  = SA;
        bus.C0_i  = 4'ha;
`ifdef MULT_ARB_STALL_EN
        bus.P_rdy_i = 1'b1;
`endif
        model_reset();
        #2;
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_vld", 32'(bus.P_vld_o), 32'd0);
        chk("rst_p", 32'(bus.P_o), 32'd0);
        chk("rst_id", 32'(bus.P_id_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].c, tbl[i].sp, tbl[i].c0, 1'b1, g);
            chk($sformatf("vec%0d_gnt", i), 32'(g), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d_vld", i), 32'(bus.P_vld_o), 32'(tbl[i].vld));
            chk($sformatf("vec%0d_id", i), 32'(bus.P_id_o), 32'(tbl[i].id));
            chk($sformatf("vec%0d_p", i), 32'(bus.P_o), 32'(tbl[i].p));
        end

        // Asynchronous reset with two items in flight.
        step(4'hf, CA, SA, 4'ha, 1'b1, g);
        step(4'hf, CA, SA, 4'ha, 1'b1, g);
        #2 rst = 1'b1;
        #1;
        chk("midrst_vld", 32'(bus.P_vld_o), 32'd0);
        chk("midrst_gnt", 32'(bus.gnt_o), 32'd0);
        #1 rst = 1'b0;
        model_reset();
        step(4'hf, CA, SA, 4'ha, 1'b1, g);
        chk("midrst_first", 32'(g), 32'h1);
        step(4'h0, CA, SA, 4'ha, 1'b1, g);
        step(4'h0, CA, SA, 4'ha, 1'b1, g);

`ifdef MULT_ARB_STALL_EN
        // Fill the pipe, stall three cycles, then release.
        do_reset();
        step(4'hf, CA, SA, 4'ha, 1'b1, g);
        step(4'hf, CA, SA, 4'ha, 1'b1, g);
        for (int i = 0; i < 3; i++) begin
            step(4'hf, CA, SA, 4'ha, 1'b0, g);
            chk("stall_gnt", 32'(g), 32'd0);
            chk("stall_p", 32'(bus.P_o), 32'h011);
        end
        step(4'hf, CA, SA, 4'ha, 1'b1, g);
        chk("stall_resume", 32'(g), 32'h4);
        for (int i = 0; i < 3; i++) step(4'h0, CA, SA, 4'ha, 1'b1, g);
`endif

        // Randomized traffic; each requester holds its operands until granted.
        do_reset();
        pend = '0;
        oc0  = '0;
        for (int k = 0; k < 4; k++) begin
            oc[k] = '0;
            os[k] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    oc[k]   = 8'($urandom);
                    os[k]   = 8'($urandom);
                    oc0[k]  = 1'($urandom);
                end
            end
            cv = {oc[3], oc[2], oc[1], oc[0]};
            sv = {os[3], os[2], os[1], os[0]};
`ifdef MULT_ARB_STALL_EN
            rdy_r = ($urandom_range(0, 3) != 0);
`else
            rdy_r = 1'b1;
`endif
            step(pend, cv, sv, oc0, rdy_r, g);
            pend = pend & ~g;
        end
        for (int n = 0; n < 4; n++) step(4'h0, cv, sv, oc0, 1'b1, g);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
